// File: rtl/pic_pkg.sv
// Shared state encoding, OCW2 command codes and level/priority helpers
// for the interrupt acknowledge sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PENDING     = 2'd1,
    WAIT_SECOND = 2'd2,
    VECTOR      = 2'd3
  } state_t;

  // OCW2 bits [7:5] = {R, SL, EOI}
  localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SPEC_EOI     = 3'b011;
  localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SPEC_EOI = 3'b111;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  localparam logic [2:0] RESET_ROTATE   = 3'b111;

  // Rotate right so that bit 0 of the result is bit n of the input.
  function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  function automatic logic [2:0] onehot_to_level(input logic [7:0] v);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) lvl = 3'(i);
    end
    return lvl;
  endfunction

  function automatic logic [7:0] level_to_onehot(input logic [2:0] lvl);
    return 8'h01 << lvl;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Combinational rotated-priority selector: picks the highest-priority request
// strictly above the highest level currently in service (fully nested mode).
module priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] request,
  input  logic [7:0] highest_level_in_service,
  input  logic [2:0] priority_rotate,
  output logic       candidate_valid,
  output logic [2:0] candidate_level,
  output logic [7:0] candidate_onehot
);

  logic [2:0] shift;
  logic [7:0] rot_req;
  logic [7:0] rot_isr;
  logic [3:0] req_rank;
  logic [3:0] isr_rank;

  // Rank 0 is the highest priority; rank 8 means nothing present.
  always_comb begin
    shift    = priority_rotate + 3'd1;
    rot_req  = rotate_right(request, shift);
    rot_isr  = rotate_right(highest_level_in_service, shift);
    req_rank = 4'd8;
    isr_rank = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) req_rank = 4'(i);
      if (rot_isr[i]) isr_rank = 4'(i);
    end
    candidate_valid  = (req_rank < isr_rank);
    candidate_level  = req_rank[2:0] + shift;
    candidate_onehot = candidate_valid ? level_to_onehot(candidate_level) : 8'h00;
  end

endmodule

// File: rtl/inta_sequencer.sv
// INTA handshake sequencer: raises int_out, answers the two INTA pulses with
// ISR/IRR updates and the vector, and executes OCW2 EOI/rotation commands.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] request,
  input  logic [7:0] in_service_register,
  input  logic [7:0] highest_level_in_service,
  input  logic       inta_strobe,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  output logic       int_out,
  output logic [7:0] interrupt,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_request,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output state_t     fsm_state
);

  // Handshake: int_out holds until the first inta_strobe; the cycle after each
  // strobe carries its one-cycle response (interrupt/clear_request, then
  // vector_valid with vector_out). Strobes outside PENDING/WAIT_SECOND are ignored.

  state_t     state, state_next;
  logic       int_out_next;
  logic [7:0] interrupt_next, clear_next, eoi_next;
  logic [2:0] rotate_next;
  logic [7:0] vector_out_next;
  logic       vector_valid_next;
  logic [2:0] latched_level, latched_next;
  logic       spurious, spurious_next;
  logic       rotate_aeoi, rotate_aeoi_next;

  logic       cand_valid;
  logic [2:0] cand_level;
  logic [7:0] cand_onehot;
  logic [2:0] ocw_level;
  logic [7:0] ns_target;
  logic       ocw2_unused;

  assign ocw_level   = ocw2_data[2:0];
  assign ocw2_unused = ^ocw2_data[4:3];
  // Only clear a level the ISR actually holds.
  assign ns_target   = highest_level_in_service & in_service_register;
  assign fsm_state   = state;

  priority_resolver u_resolver (
    .request                  (request),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .candidate_valid          (cand_valid),
    .candidate_level          (cand_level),
    .candidate_onehot         (cand_onehot)
  );

  always_comb begin
    state_next        = state;
    int_out_next      = int_out;
    interrupt_next    = 8'h00;
    clear_next        = 8'h00;
    eoi_next          = 8'h00;
    vector_valid_next = 1'b0;
    vector_out_next   = vector_out;
    latched_next      = latched_level;
    spurious_next     = spurious;
    rotate_next       = priority_rotate;
    rotate_aeoi_next  = rotate_aeoi;

    case (state)
      IDLE: begin
        if (cand_valid) begin
          state_next   = PENDING;
          int_out_next = 1'b1;
        end
      end
      PENDING: begin
        if (inta_strobe) begin
          state_next   = WAIT_SECOND;
          int_out_next = 1'b0;
          if (cand_valid) begin
            latched_next   = cand_level;
            spurious_next  = 1'b0;
            interrupt_next = cand_onehot;
            clear_next     = cand_onehot;
          end else begin
            latched_next  = SPURIOUS_LEVEL;
            spurious_next = 1'b1;
          end
        end
      end
      WAIT_SECOND: begin
        if (inta_strobe) begin
          state_next        = VECTOR;
          vector_out_next   = {vector_base, latched_level};
          vector_valid_next = 1'b1;
          if (auto_eoi && !spurious) begin
            eoi_next = level_to_onehot(latched_level);
            if (rotate_aeoi) rotate_next = latched_level;
          end
        end
      end
      VECTOR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // OCW2 is applied after the FSM so its rotation overrides an AEOI rotation.
    if (ocw2_write) begin
      case (ocw2_data[7:5])
        OCW2_NS_EOI: eoi_next = eoi_next | ns_target;
        OCW2_SPEC_EOI: eoi_next = eoi_next | level_to_onehot(ocw_level);
        OCW2_ROT_NS_EOI: begin
          if (|ns_target) begin
            eoi_next    = eoi_next | ns_target;
            rotate_next = onehot_to_level(ns_target);
          end
        end
        OCW2_ROT_SPEC_EOI: begin
          eoi_next    = eoi_next | level_to_onehot(ocw_level);
          rotate_next = ocw_level;
        end
        OCW2_SET_PRIO:     rotate_next = ocw_level;
        OCW2_SET_ROT_AEOI: rotate_aeoi_next = 1'b1;
        OCW2_CLR_ROT_AEOI: rotate_aeoi_next = 1'b0;
        OCW2_NOP:          ;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      int_out          <= 1'b0;
      interrupt        <= 8'h00;
      clear_request    <= 8'h00;
      end_of_interrupt <= 8'h00;
      priority_rotate  <= RESET_ROTATE;
      vector_out       <= 8'h00;
      vector_valid     <= 1'b0;
      latched_level    <= 3'd0;
      spurious         <= 1'b0;
      rotate_aeoi      <= 1'b0;
    end else begin
      state            <= state_next;
      int_out          <= int_out_next;
      interrupt        <= interrupt_next;
      clear_request    <= clear_next;
      end_of_interrupt <= eoi_next;
      priority_rotate  <= rotate_next;
      vector_out       <= vector_out_next;
      vector_valid     <= vector_valid_next;
      latched_level    <= latched_next;
      spurious         <= spurious_next;
      rotate_aeoi      <= rotate_aeoi_next;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: table of full INTA cycles under several
// rotations plus hand-written EOI, AEOI, spurious and reset sequences.
module tb_inta_sequencer;
  import pic_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic       inta_strobe;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       int_out;
  logic [7:0] interrupt;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] clear_request;
  logic [7:0] vector_out;
  logic       vector_valid;
  state_t     fsm_state;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [2:0] prio;
    logic [7:0] req;
    logic [7:0] hlis;
    logic [4:0] base;
    logic       exp_int;
    logic [7:0] exp_irq;
    logic [7:0] exp_vec;
  } vec_t;

  vec_t vecs[10];

  inta_sequencer dut (
    .clk                      (clk),
    .rst                      (rst),
    .request                  (request),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .inta_strobe              (inta_strobe),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .vector_base              (vector_base),
    .auto_eoi                 (auto_eoi),
    .int_out                  (int_out),
    .interrupt                (interrupt),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .clear_request            (clear_request),
    .vector_out               (vector_out),
    .vector_valid             (vector_valid),
    .fsm_state                (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 8'h%02h expected 8'h%02h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are read there too.
  task automatic apply_reset();
    rst = 1'b0;
    request = 8'h00;
    in_service_register = 8'h00;
    highest_level_in_service = 8'h00;
    inta_strobe = 1'b0;
    ocw2_write = 1'b0;
    ocw2_data = 8'h00;
    vector_base = 5'h08;
    auto_eoi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_inta();
    inta_strobe = 1'b1;
    @(negedge clk);
    inta_strobe = 1'b0;
  endtask

  task automatic write_ocw2(input logic [7:0] d);
    ocw2_write = 1'b1;
    ocw2_data = d;
    @(negedge clk);
    ocw2_write = 1'b0;
  endtask

  task automatic wait_int_out(input string name);
    int n;
    n = 0;
    while (!int_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!int_out) begin
      fails++;
      $display("FAIL %s: int_out got 0 expected 1 within 20 cycles", name);
    end
  endtask

  initial begin
    vecs[0] = '{3'd7, 8'h0A, 8'h00, 5'h08, 1'b1, 8'h02, 8'h41};
    vecs[1] = '{3'd7, 8'h10, 8'h04, 5'h08, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{3'd7, 8'h01, 8'h04, 5'h08, 1'b1, 8'h01, 8'h40};
    vecs[3] = '{3'd3, 8'h11, 8'h00, 5'h08, 1'b1, 8'h10, 8'h44};
    vecs[4] = '{3'd4, 8'h11, 8'h00, 5'h1F, 1'b1, 8'h01, 8'hF8};
    vecs[5] = '{3'd0, 8'h81, 8'h00, 5'h10, 1'b1, 8'h80, 8'h87};
    vecs[6] = '{3'd7, 8'h00, 8'h00, 5'h08, 1'b0, 8'h00, 8'h00};
    vecs[7] = '{3'd2, 8'h08, 8'h08, 5'h08, 1'b0, 8'h00, 8'h00};
    vecs[8] = '{3'd2, 8'h0C, 8'h08, 5'h08, 1'b0, 8'h00, 8'h00};
    vecs[9] = '{3'd5, 8'h80, 8'h01, 5'h02, 1'b1, 8'h80, 8'h17};

    // Reset state, observed while reset is held
    rst = 1'b0;
    request = 8'h00;
    in_service_register = 8'h00;
    highest_level_in_service = 8'h00;
    inta_strobe = 1'b0;
    ocw2_write = 1'b0;
    ocw2_data = 8'h00;
    vector_base = 5'h08;
    auto_eoi = 1'b0;
    @(negedge clk);
    check("reset priority_rotate", {5'd0, priority_rotate}, 8'h07);
    check("reset int_out", {7'd0, int_out}, 8'h00);
    check("reset interrupt", interrupt, 8'h00);
    check("reset vector_valid", {7'd0, vector_valid}, 8'h00);
    check("reset vector_out", vector_out, 8'h00);
    check("reset state", {6'd0, fsm_state}, {6'd0, IDLE});

    // Table of full INTA cycles
    for (int i = 0; i < 10; i++) begin
      apply_reset();
      write_ocw2({3'b110, 2'b00, vecs[i].prio});
      check($sformatf("v%0d priority_rotate", i), {5'd0, priority_rotate}, {5'd0, vecs[i].prio});
      check($sformatf("v%0d set-prio eoi", i), end_of_interrupt, 8'h00);
      request = vecs[i].req;
      highest_level_in_service = vecs[i].hlis;
      in_service_register = vecs[i].hlis;
      vector_base = vecs[i].base;
      @(negedge clk);
      check($sformatf("v%0d int_out", i), {7'd0, int_out}, {7'd0, vecs[i].exp_int});
      if (vecs[i].exp_int) begin
        pulse_inta();
        check($sformatf("v%0d interrupt", i), interrupt, vecs[i].exp_irq);
        check($sformatf("v%0d clear_request", i), clear_request, vecs[i].exp_irq);
        check($sformatf("v%0d int_out after inta", i), {7'd0, int_out}, 8'h00);
        exp_q.push_back(vecs[i].exp_vec);
        pulse_inta();
        check($sformatf("v%0d vector_valid", i), {7'd0, vector_valid}, 8'h01);
        if (exp_q.size() > 0) check($sformatf("v%0d vector_out", i), vector_out, exp_q.pop_front());
      end
      request = 8'h00;
      @(negedge clk);
    end

    // Rotate + non-specific EOI, then selection under the new rotation
    apply_reset();
    in_service_register = 8'h08;
    highest_level_in_service = 8'h08;
    write_ocw2(8'hA0);
    check("rot-ns eoi", end_of_interrupt, 8'h08);
    check("rot-ns priority_rotate", {5'd0, priority_rotate}, 8'h03);
    @(negedge clk);
    check("rot-ns eoi one cycle", end_of_interrupt, 8'h00);
    in_service_register = 8'h00;
    highest_level_in_service = 8'h00;
    request = 8'h11;
    wait_int_out("rot-ns int_out");
    pulse_inta();
    check("rot-ns interrupt", interrupt, 8'h10);

    // AEOI with rotate_aeoi
    apply_reset();
    auto_eoi = 1'b1;
    write_ocw2(8'h80);
    check("aeoi set eoi", end_of_interrupt, 8'h00);
    check("aeoi set rotate", {5'd0, priority_rotate}, 8'h07);
    request = 8'h40;
    wait_int_out("aeoi int_out");
    pulse_inta();
    check("aeoi interrupt", interrupt, 8'h40);
    check("aeoi eoi first inta", end_of_interrupt, 8'h00);
    request = 8'h00;
    pulse_inta();
    check("aeoi eoi", end_of_interrupt, 8'h40);
    check("aeoi vector_valid", {7'd0, vector_valid}, 8'h01);
    check("aeoi vector_out", vector_out, 8'h46);
    check("aeoi priority_rotate", {5'd0, priority_rotate}, 8'h06);

    // Spurious: request withdrawn before the first INTA
    apply_reset();
    auto_eoi = 1'b1;
    request = 8'h04;
    wait_int_out("spur int_out");
    request = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("spur int_out held", {7'd0, int_out}, 8'h01);
    check("spur state", {6'd0, fsm_state}, {6'd0, PENDING});
    pulse_inta();
    check("spur interrupt", interrupt, 8'h00);
    check("spur clear_request", clear_request, 8'h00);
    check("spur int_out low", {7'd0, int_out}, 8'h00);
    pulse_inta();
    check("spur vector_out", vector_out, 8'h47);
    check("spur vector_valid", {7'd0, vector_valid}, 8'h01);
    check("spur eoi", end_of_interrupt, 8'h00);
    @(negedge clk);
    check("spur vector held", vector_out, 8'h47);

    // Non-specific EOI with empty ISR, specific EOI on levels not in service
    apply_reset();
    write_ocw2(8'hA0);
    check("ns empty eoi", end_of_interrupt, 8'h00);
    check("ns empty rotate", {5'd0, priority_rotate}, 8'h07);
    write_ocw2(8'hE5);
    check("rot-spec eoi", end_of_interrupt, 8'h20);
    check("rot-spec rotate", {5'd0, priority_rotate}, 8'h05);
    write_ocw2(8'h62);
    check("spec eoi", end_of_interrupt, 8'h04);
    check("spec rotate kept", {5'd0, priority_rotate}, 8'h05);
    write_ocw2(8'h40);
    check("nop eoi", end_of_interrupt, 8'h00);

    // Simultaneous AEOI and OCW2 rotate+specific EOI
    apply_reset();
    auto_eoi = 1'b1;
    write_ocw2(8'h80);
    request = 8'h02;
    wait_int_out("both int_out");
    pulse_inta();
    check("both interrupt", interrupt, 8'h02);
    request = 8'h00;
    inta_strobe = 1'b1;
    ocw2_write = 1'b1;
    ocw2_data = 8'hE4;
    @(negedge clk);
    inta_strobe = 1'b0;
    ocw2_write = 1'b0;
    check("both eoi", end_of_interrupt, 8'h12);
    check("both rotate", {5'd0, priority_rotate}, 8'h04);
    check("both vector_out", vector_out, 8'h41);

    // Reset mid-handshake, then stray INTA in IDLE
    apply_reset();
    request = 8'h04;
    wait_int_out("midrst int_out");
    pulse_inta();
    check("midrst interrupt", interrupt, 8'h04);
    #2;
    rst = 1'b0;
    #1;
    check("midrst async state", {6'd0, fsm_state}, {6'd0, IDLE});
    check("midrst async interrupt", interrupt, 8'h00);
    @(negedge clk);
    request = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    pulse_inta();
    check("midrst vector_valid", {7'd0, vector_valid}, 8'h00);
    check("midrst vector_out", vector_out, 8'h00);
    check("idle inta interrupt", interrupt, 8'h00);
    check("idle inta int_out", {7'd0, int_out}, 8'h00);
    check("idle inta state", {6'd0, fsm_state}, {6'd0, IDLE});

    // Asynchronous reset while int_out is asserted
    request = 8'h01;
    wait_int_out("async int_out");
    #2;
    rst = 1'b0;
    #1;
    check("async int_out", {7'd0, int_out}, 8'h00);
    check("async rotate", {5'd0, priority_rotate}, 8'h07);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
